// File: rtl/riscv_pkg.sv
// Shared core package: ALU op codes and datapath width defaults.
// Codes not listed here decode to a zero result in the execute unit.
package riscv_pkg;

  localparam int ALUOP_WIDTH        = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;

  localparam logic [ALUOP_WIDTH-1:0] ADD_OP  = 4'd0;
  localparam logic [ALUOP_WIDTH-1:0] SUB_OP  = 4'd1;
  localparam logic [ALUOP_WIDTH-1:0] SLL_OP  = 4'd2;
  localparam logic [ALUOP_WIDTH-1:0] SLT_OP  = 4'd3;
  localparam logic [ALUOP_WIDTH-1:0] SLTU_OP = 4'd4;
  localparam logic [ALUOP_WIDTH-1:0] XOR_OP  = 4'd5;
  localparam logic [ALUOP_WIDTH-1:0] SRL_OP  = 4'd6;
  localparam logic [ALUOP_WIDTH-1:0] SRA_OP  = 4'd7;
  localparam logic [ALUOP_WIDTH-1:0] OR_OP   = 4'd8;
  localparam logic [ALUOP_WIDTH-1:0] AND_OP  = 4'd9;
  localparam logic [ALUOP_WIDTH-1:0] PASS_OP = 4'd10;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU datapath: (op, a, b) -> result.
// Shift amounts use only the low SHAMT_WIDTH bits of b.
module alu_exec_core
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic [ALUOP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]  a,
  input  logic [DATA_WIDTH-1:0]  b,
  output logic [DATA_WIDTH-1:0]  result
);

  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   lt_s;
  logic                   lt_u;

  assign shamt = b[SHAMT_WIDTH-1:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;

  always_comb begin
    result = '0;
    unique case (1'b1)
      (op == ADD_OP):  result = a + b;
      (op == SUB_OP):  result = a - b;
      (op == SLL_OP):  result = a << shamt;
      (op == SRL_OP):  result = a >> shamt;
      (op == SRA_OP):  result = $signed(a) >>> shamt;
      (op == SLT_OP):  result = {{(DATA_WIDTH-1){1'b0}}, lt_s};
      (op == SLTU_OP): result = {{(DATA_WIDTH-1){1'b0}}, lt_u};
      (op == XOR_OP):  result = a ^ b;
      (op == OR_OP):   result = a | b;
      (op == AND_OP):  result = a & b;
      (op == PASS_OP): result = b;
      default:         result = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage execute pipe: S1 captures operands, S2 registers the ALU result.
// Optional o_zero output is built when ALU_EXEC_ZERO_FLAG_EN is defined.
module alu_exec_pipe
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int TID_WIDTH   = 4,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_valid,
  input  logic [ALUOP_WIDTH-1:0] i_ALUOp,
  input  logic [DATA_WIDTH-1:0]  i_op_a,
  input  logic [DATA_WIDTH-1:0]  i_op_b,
  input  logic [TID_WIDTH-1:0]   i_tid,
  input  logic                   i_stall,
  input  logic                   i_flush,
  output logic                   o_valid,
  output logic [DATA_WIDTH-1:0]  o_result,
  output logic [TID_WIDTH-1:0]   o_tid
`ifdef ALU_EXEC_ZERO_FLAG_EN
  ,
  output logic                   o_zero
`endif
);

  logic                   s1_valid_q, s1_valid_d;
  logic [ALUOP_WIDTH-1:0] s1_op_q,    s1_op_d;
  logic [DATA_WIDTH-1:0]  s1_a_q,     s1_a_d;
  logic [DATA_WIDTH-1:0]  s1_b_q,     s1_b_d;
  logic [TID_WIDTH-1:0]   s1_tid_q,   s1_tid_d;
  logic                   o_valid_q,  o_valid_d;
  logic [DATA_WIDTH-1:0]  o_result_q, o_result_d;
  logic [TID_WIDTH-1:0]   o_tid_q,    o_tid_d;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   load;

  alu_exec_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_core (
    .op     (s1_op_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
    .result (alu_res)
  );

  // Flush beats stall; data may load on a flush since valids are cleared.
  assign load = i_flush | ~i_stall;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_tid_d   = s1_tid_q;
    o_valid_d  = o_valid_q;
    o_result_d = o_result_q;
    o_tid_d    = o_tid_q;
    if (load) begin
      s1_op_d    = i_ALUOp;
      s1_a_d     = i_op_a;
      s1_b_d     = i_op_b;
      s1_tid_d   = i_tid;
      o_result_d = alu_res;
      o_tid_d    = s1_tid_q;
      s1_valid_d = i_valid & ~i_flush;
      o_valid_d  = s1_valid_q & ~i_flush;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_tid_q   <= '0;
      o_valid_q  <= 1'b0;
      o_result_q <= '0;
      o_tid_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_tid_q   <= s1_tid_d;
      o_valid_q  <= o_valid_d;
      o_result_q <= o_result_d;
      o_tid_q    <= o_tid_d;
    end
  end

  assign o_valid  = o_valid_q;
  assign o_result = o_result_q;
  assign o_tid    = o_tid_q;

`ifdef ALU_EXEC_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (i_flush)
      zero_d = 1'b0;
    else if (!i_stall)
      zero_d = (alu_res == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      zero_q <= 1'b0;
    else
      zero_q <= zero_d;
  end

  assign o_zero = zero_q;
`endif

endmodule
